ov7670_capture: RTL
===================

# ov7670_capture

Single-clock pixel-capture stage driven by the OV7670 camera pixel clock. Synchronises to the sensor's VSYNC/HREF framing and assembles byte pairs into 16-bit RGB565 pixels. Issues one write per pixel (enable, linear address, data) to the write port of the dual-clock frame-buffer RAM. Signals frame completion to downstream control logic.

## Interface
Parameters:
- H_PIXELS, 640, active pixels per line written to the buffer
- V_LINES, 480, active lines per frame written to the buffer
- ADDR_BITW, derived localparam = log2(H_PIXELS*V_LINES) (ceil); not overridable

Ports:
- clock  in  1  camera PCLK; all logic on its rising edge
- n_rst  in  1  reset, asynchronous, active-low
- enable  in  1  capture permission, sampled only at frame start
- vsync  in  1  sensor VSYNC, high during vertical blanking
- href  in  1  sensor HREF, high while line bytes are valid
- cam_data  in  8  sensor data byte
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  ADDR_BITW  linear pixel address, line*H_PIXELS + col
- wr_data  out  16  RGB565 pixel, {first byte, second byte}
- frame_done  out  1  one-cycle pulse at the end of a captured frame
- busy  out  1  high while in CAPTURE

## Operation
- Edge detection: vsync_d and href_d are one-cycle delayed copies. vs_fall = vsync_d & ~vsync; vs_rise = ~vsync_d & vsync; hr_fall = href_d & ~href.
- FSM states: SYNC, IDLE, CAPTURE. Reset state is SYNC.
  - SYNC: waits for vsync==1, which discards any partial frame after reset → IDLE.
  - IDLE: on vs_fall, go to CAPTURE if enable==1; otherwise stay in IDLE. No writes occur in IDLE.
  - CAPTURE: on vs_rise → IDLE and pulse frame_done. vs_rise takes priority over any same-cycle href activity.
- On entry to CAPTURE, clear col, line, line_base and phase.
- While in CAPTURE with href==1, phase toggles on every byte.
  - phase 0: latch cam_data into hi_byte.
  - phase 1: write {hi_byte, cam_data} if col<H_PIXELS and line<V_LINES; col increments, saturating at H_PIXELS.
- On hr_fall in CAPTURE:
  - col←0, phase←0.
  - If line<V_LINES: line←line+1 and line_base←line_base+H_PIXELS.
  - A dangling odd byte is discarded.
- wr_addr = line_base + col. The address is formed by addition only; no multiplier.
- Boundaries:
  - Over-long lines: extra pixels are dropped.
  - Extra lines: dropped; no address wraps past H_PIXELS*V_LINES-1.
  - Short lines or frames: the remaining locations are left unwritten.
  - vs_rise mid-line ends the frame immediately, and frame_done still pulses.
- enable changes during CAPTURE have no effect until the next frame start.
- Reset mid-frame: all outputs return to reset values immediately, and the FSM returns to SYNC.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, busy=0. Internal counters, phase and hi_byte are also cleared.
- All outputs are registered.
- Write latency: wr_en, wr_addr and wr_data are valid one cycle after the edge that samples the second byte of a pair. wr_en is high for exactly one cycle.
- Maximum write rate: one write every 2 cycles.
- frame_done rises one cycle after the edge on which vsync is first sampled high. busy falls in the same cycle.
- busy rises one cycle after the edge on which vsync is first sampled low in IDLE with enable==1.
- First capturable byte: the first href==1 sample after entering CAPTURE. The sensor guarantees at least 2 cycles from VSYNC fall to the first HREF.

## Structure
- Shared common header holds:
  - the log2 function, shared with the frame-buffer RAM;
  - OV7670 constants: default H_PIXELS/V_LINES, PIXEL_BITW=16, BYTE_BITW=8;
  - the FSM state encodings SYNC/IDLE/CAPTURE.
- No sub-module. Edge detection, FSM and counters stay in one module.

## Test plan
Bench parameters: H_PIXELS=4, V_LINES=3.
- Reset, then run a full frame of 3 lines × 8 bytes (bytes 0x00..0x17) with enable=1 → 12 writes, addr 0..11, data 0x0001,0x0203,…,0x1617; one frame_done pulse.
- Frame starting before reset release, or with vsync low at reset exit → no writes until one full vsync high/low cycle completes.
- Line of 11 bytes, then 6 lines → only 4 writes per line and only lines 0..2 written; last addr 11; odd byte dropped, and the next line starts at phase 0.
- enable=0 at vs_fall, then enable=1 mid-frame → no writes that frame; the next frame is captured normally.
- vs_rise after 1.5 lines → writes at addr 0..5, frame_done pulses, busy=0.
- n_rst low for 1 cycle mid-line, e.g. after addr 2 → outputs zero immediately, no further writes until the next full frame, and capture then restarts at addr 0.

Source files
------------

// File: rtl/ov7670_capture_pkg.sv
// ov7670_capture_pkg
//   Definitions shared by the OV7670 capture stage and the frame-buffer RAM:
//   the ceil-log2 helper, default frame geometry, pixel/byte widths and the
//   capture FSM state encoding.
package ov7670_capture_pkg;

  localparam int unsigned H_PIXELS_DEF = 640;
  localparam int unsigned V_LINES_DEF  = 480;
  localparam int unsigned PIXEL_BITW   = 16;
  localparam int unsigned BYTE_BITW    = 8;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // ceil(log2(n)), never less than 1 so derived vectors stay non-empty.
  function automatic int unsigned log2c(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((longint'(1) << r) < longint'(n)) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/ov7670_capture_if.sv
// ov7670_capture_if
//   Frame-buffer write port driven by the capture stage.
//   wr_en   : one-cycle write strobe
//   wr_addr : linear pixel address, line*H_PIXELS + col
//   wr_data : RGB565 pixel {first byte, second byte}
//   master modport drives the port (capture stage); slave receives it (RAM).
interface ov7670_capture_if
  import ov7670_capture_pkg::*;
#(
  parameter int unsigned H_PIXELS = H_PIXELS_DEF,
  parameter int unsigned V_LINES  = V_LINES_DEF
) ();

  localparam int unsigned ADDR_BITW = log2c(H_PIXELS * V_LINES);

  logic                  wr_en;
  logic [ADDR_BITW-1:0]  wr_addr;
  logic [PIXEL_BITW-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/ov7670_capture.sv
// ov7670_capture
//   Pixel-capture stage clocked by the OV7670 PCLK. Tracks VSYNC/HREF framing,
//   pairs sensor bytes into RGB565 pixels and writes them to the frame buffer.
//   clock      : camera PCLK, rising edge
//   n_rst      : asynchronous active-low reset
//   enable     : capture permission, sampled at frame start only
//   vsync/href : sensor framing strobes
//   cam_data   : sensor data byte
//   wr         : frame-buffer write port (master)
//   frame_done : one-cycle pulse when a captured frame ends
//   busy       : high while capturing a frame
module ov7670_capture
  import ov7670_capture_pkg::*;
#(
  parameter int unsigned H_PIXELS = H_PIXELS_DEF,
  parameter int unsigned V_LINES  = V_LINES_DEF
) (
  input  logic                 clock,
  input  logic                 n_rst,
  input  logic                 enable,
  input  logic                 vsync,
  input  logic                 href,
  input  logic [BYTE_BITW-1:0] cam_data,
  ov7670_capture_if.master     wr,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int unsigned ADDR_BITW = log2c(H_PIXELS * V_LINES);
  localparam int unsigned COL_BITW  = log2c(H_PIXELS + 1);
  localparam int unsigned LINE_BITW = log2c(V_LINES + 1);

  localparam logic [COL_BITW-1:0]  COL_MAX   = COL_BITW'(H_PIXELS);
  localparam logic [LINE_BITW-1:0] LINE_MAX  = LINE_BITW'(V_LINES);
  localparam logic [ADDR_BITW-1:0] LINE_STEP = ADDR_BITW'(H_PIXELS);

  state_t                 state_q, state_d;
  logic                   vsync_q, href_q;
  logic [COL_BITW-1:0]    col_q, col_d;
  logic [LINE_BITW-1:0]   line_q, line_d;
  logic [ADDR_BITW-1:0]   base_q, base_d;
  logic                   phase_q, phase_d;
  logic [BYTE_BITW-1:0]   hi_q, hi_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_BITW-1:0]   wr_addr_q, wr_addr_d;
  logic [PIXEL_BITW-1:0]  wr_data_q, wr_data_d;
  logic                   frame_done_q, frame_done_d;
  logic                   busy_q, busy_d;

  logic vs_fall, vs_rise, hr_fall;

  assign vs_fall = vsync_q & ~vsync;
  assign vs_rise = ~vsync_q & vsync;
  assign hr_fall = href_q & ~href;

  // State register
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) state_q <= ST_SYNC;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC:    if (vsync)             state_d = ST_IDLE;
      ST_IDLE:    if (vs_fall && enable) state_d = ST_CAPTURE;
      ST_CAPTURE: if (vs_rise)           state_d = ST_IDLE;
      default:                           state_d = ST_SYNC;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    col_d        = col_q;
    line_d       = line_q;
    base_d       = base_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = (state_q == ST_CAPTURE) && vs_rise;
    busy_d       = (state_d == ST_CAPTURE);

    if (state_q != ST_CAPTURE && state_d == ST_CAPTURE) begin
      col_d   = '0;
      line_d  = '0;
      base_d  = '0;
      phase_d = 1'b0;
    end else if (state_q == ST_CAPTURE && !vs_rise) begin
      // vs_rise wins: a byte arriving alongside the end of frame is ignored.
      if (href) begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          hi_d = cam_data;
        end else begin
          if (col_q < COL_MAX && line_q < LINE_MAX) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base_q + ADDR_BITW'(col_q);
            wr_data_d = {hi_q, cam_data};
          end
          if (col_q < COL_MAX) col_d = col_q + COL_BITW'(1);
        end
      end else if (hr_fall) begin
        // Dropping phase here discards any dangling odd byte of the line.
        col_d   = '0;
        phase_d = 1'b0;
        if (line_q < LINE_MAX) begin
          line_d = line_q + LINE_BITW'(1);
          base_d = base_q + LINE_STEP;
        end
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      col_q        <= '0;
      line_q       <= '0;
      base_q       <= '0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      vsync_q      <= vsync;
      href_q       <= href;
      col_q        <= col_d;
      line_q       <= line_d;
      base_q       <= base_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign wr.wr_en    = wr_en_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_data  = wr_data_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;

endmodule
